// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM state encoding, ACK/NACK bus levels and the
// default glitch-filter length used by both the master and the slave.
package i2c_pkg;

    // Default number of equal synchronized samples needed to accept a new line level.
    localparam int unsigned I2C_FILTER_LEN = 3;

    // Bus level of the ninth bit.
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck,
        StIgnore
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Input conditioning for one open-drain bus line.
//   clk, rst_n : system clock, async active-low reset
//   line_in    : raw bus level
//   line_out   : synchronized, glitch-filtered level (resets to the idle level 1)
//   rise, fall : one-clk pulses, asserted in the same clk that line_out takes its new level
// Latency from line_in to line_out/rise/fall is 2 + FILTER_LEN clk.
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int unsigned FILTER_LEN = I2C_FILTER_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic line_out,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync_q;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], line_in};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            // cnt_q counts consecutive samples that disagree with the accepted level.
            if (sync_q[1] != level_q) begin
                if (cnt_q == CW'(FILTER_LEN - 1)) begin
                    level_q <= sync_q[1];
                    rise_q  <= sync_q[1];
                    fall_q  <= ~sync_q[1];
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign line_out = level_q;
    assign rise     = rise_q;
    assign fall     = fall_q;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave with an internal byte register file and a 1-byte word pointer.
//   clk, rst_n          : system clock, async active-low reset
//   scl_in, sda_in      : bus levels (SCL is never driven)
//   sda_oen             : 0 pulls SDA low, 1 releases it
//   usr_addr, usr_rdata : combinational user-side register read
//   wr_strobe/addr/data : one-clk report of each bus write commit
//   busy                : high from START to STOP
//   flag_start/stop     : one-clk pulses per (repeated) START / STOP
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter int unsigned REG_NUM    = 16,
    parameter int unsigned FILTER_LEN = I2C_FILTER_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oen,
    input  logic [7:0] usr_addr,
    output logic [7:0] usr_rdata,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       flag_start,
    output logic       flag_stop
);

    localparam int unsigned AW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .line_in  (scl_in),
        .line_out (scl_f),
        .rise     (scl_rise),
        .fall     (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .line_in  (sda_in),
        .line_out (sda_f),
        .rise     (sda_rise),
        .fall     (sda_fall)
    );

    i2c_state_e    state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          sda_oen_q, sda_oen_d;
    logic          busy_q, busy_d;
    logic          flag_start_q, flag_start_d;
    logic          flag_stop_q, flag_stop_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    regs_q [REG_NUM];

    logic          start_cond, stop_cond;
    logic [7:0]    rx_byte, rd_byte;
    logic [AW-1:0] ptr_inc;

    assign start_cond = sda_fall & scl_f;
    assign stop_cond  = sda_rise & scl_f;
    assign rx_byte    = {shreg_q[6:0], sda_f};
    assign rd_byte    = regs_q[ptr_q];
    assign ptr_inc    = ptr_q + AW'(1);  // REG_NUM is a power of 2, so this wraps

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        ptr_d        = ptr_q;
        sda_oen_d    = sda_oen_q;
        busy_d       = busy_q;
        flag_start_d = 1'b0;
        flag_stop_d  = 1'b0;
        wr_strobe_d  = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        if (start_cond) begin
            state_d      = StAddr;
            bit_cnt_d    = '0;
            sda_oen_d    = 1'b1;
            busy_d       = 1'b1;
            flag_start_d = 1'b1;
        end else if (stop_cond) begin
            state_d     = StIdle;
            sda_oen_d   = 1'b1;
            busy_d      = 1'b0;
            flag_stop_d = 1'b1;
        end else begin
            unique case (state_q)
                StAddr, StPtr, StWdata: begin
                    if (scl_rise) begin
                        shreg_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            if (state_q == StAddr) begin
                                state_d = (rx_byte[7:1] == SLAVE_ADDR) ? StAddrAck : StIgnore;
                            end else if (state_q == StPtr) begin
                                ptr_d   = rx_byte[AW-1:0];
                                state_d = StPtrAck;
                            end else begin
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = 8'(ptr_q);
                                wr_data_d   = rx_byte;
                                ptr_d       = ptr_inc;
                                state_d     = StWdataAck;
                            end
                        end
                    end
                end
                StAddrAck, StPtrAck, StWdataAck: begin
                    // First fall ends bit 8 (start driving ACK), second fall ends the ACK bit.
                    if (scl_fall) begin
                        if (sda_oen_q) begin
                            sda_oen_d = I2C_ACK;
                        end else begin
                            sda_oen_d = 1'b1;
                            bit_cnt_d = '0;
                            if (state_q != StAddrAck) begin
                                state_d = StWdata;
                            end else if (shreg_q[0]) begin
                                state_d   = StRdata;
                                shreg_d   = rd_byte;
                                sda_oen_d = rd_byte[7];
                            end else begin
                                state_d = StPtr;
                            end
                        end
                    end
                end
                StRdata: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oen_d = 1'b1;
                            state_d   = StRdataAck;
                        end else begin
                            shreg_d   = {shreg_q[6:0], 1'b0};
                            sda_oen_d = shreg_q[6];
                        end
                    end
                end
                StRdataAck: begin
                    if (scl_rise) begin
                        ptr_d = ptr_inc;
                        if (sda_f == I2C_NACK) begin
                            state_d = StIgnore;
                        end
                    end else if (scl_fall) begin
                        // Only reached after the master ACKed: present the next byte.
                        state_d   = StRdata;
                        bit_cnt_d = '0;
                        shreg_d   = rd_byte;
                        sda_oen_d = rd_byte[7];
                    end
                end
                StIdle, StIgnore: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            ptr_q        <= '0;
            sda_oen_q    <= 1'b1;
            busy_q       <= 1'b0;
            flag_start_q <= 1'b0;
            flag_stop_q  <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            ptr_q        <= ptr_d;
            sda_oen_q    <= sda_oen_d;
            busy_q       <= busy_d;
            flag_start_q <= flag_start_d;
            flag_stop_q  <= flag_stop_d;
            wr_strobe_q  <= wr_strobe_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    // The array is updated at the end of the wr_strobe clk, so a user read of
    // the same index during the strobe still sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_strobe_q) begin
            regs_q[wr_addr_q[AW-1:0]] <= wr_data_q;
        end
    end

    assign usr_rdata  = regs_q[usr_addr[AW-1:0]];
    assign sda_oen    = sda_oen_q;
    assign busy       = busy_q;
    assign flag_start = flag_start_q;
    assign flag_stop  = flag_stop_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: a behavioural bus master drives directed transactions;
// expected register commits go into a queue that a monitor drains on wr_strobe.
module tb_i2c_slave_regfile;

    localparam int Q = 10;  // clk from SCL edge to SDA change
    localparam int H = 20;  // clk of SCL high

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       glitch = 1'b0;
    logic       scl_in, sda_in, sda_oen;
    logic [7:0] usr_addr = 8'd0;
    logic [7:0] usr_rdata;
    logic       wr_strobe, busy, flag_start, flag_stop;
    logic [7:0] wr_addr, wr_data;

    int total = 0;
    int bad = 0;
    int starts_seen = 0, stops_seen = 0, starts_exp = 0, stops_exp = 0;
    logic oen_low_seen = 1'b0;
    logic [7:0] exp_wa[$];
    logic [7:0] exp_wd[$];

    assign scl_in = scl_m & ~glitch;
    assign sda_in = sda_m & sda_oen;

    always #5 clk = ~clk;

    i2c_slave_regfile #(
        .SLAVE_ADDR (7'h50),
        .REG_NUM    (16),
        .FILTER_LEN (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .sda_oen    (sda_oen),
        .usr_addr   (usr_addr),
        .usr_rdata  (usr_rdata),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .flag_start (flag_start),
        .flag_stop  (flag_stop)
    );

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (flag_start) starts_seen++;
            if (flag_stop) stops_seen++;
            if (!sda_oen) oen_low_seen = 1'b1;
            if (wr_strobe) begin
                if (exp_wa.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    check("wr_addr", int'(wr_addr), int'(exp_wa.pop_front()));
                    check("wr_data", int'(wr_data), int'(exp_wd.pop_front()));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
        exp_wa.push_back(a);
        exp_wd.push_back(d);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b1; wclk(H);
        sda_m = 1'b0; wclk(H);
        scl_m = 1'b0; wclk(Q);
        starts_exp++;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wclk(Q);
        scl_m = 1'b1; wclk(H);
        sda_m = 1'b1; wclk(H);
        stops_exp++;
    endtask

    task automatic write_bit(input logic b, input logic glitch_it);
        sda_m = b; wclk(Q);
        scl_m = 1'b1;
        if (glitch_it) begin
            wclk(8); glitch = 1'b1; wclk(1); glitch = 1'b0; wclk(H - 9);
        end else begin
            wclk(H);
        end
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b1; wclk(H / 2);
        b = sda_in; wclk(H / 2);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic write_byte(input string nm, input logic [7:0] d, input logic exp_ack,
                              input logic glitch_it);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(d[i], glitch_it && (i == 3));
        read_bit(a);
        check(nm, int'(a), int'(exp_ack));
    endtask

    task automatic read_byte(input string nm, input logic [7:0] exp, input logic mack);
        logic [7:0] v;
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
        check(nm, int'(v), int'(exp));
        write_bit(mack, 1'b0);
    endtask

    task automatic check_reg(input string nm, input logic [7:0] a, input logic [7:0] exp);
        usr_addr = a;
        #1;
        check(nm, int'(usr_rdata), int'(exp));
    endtask

    initial begin
        logic a;
        wclk(3);
        check("rst_sda_oen", int'(sda_oen), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_wr_strobe", int'(wr_strobe), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_flags", int'({flag_start, flag_stop}), 0);
        check_reg("rst_reg5", 8'd5, 8'h00);
        rst_n = 1'b1;
        wclk(10);

        // Single write.
        bus_start();
        write_byte("w1_addr_ack", 8'hA0, 1'b0, 1'b0);
        write_byte("w1_ptr_ack", 8'h03, 1'b0, 1'b0);
        expect_wr(8'd3, 8'h5A);
        write_byte("w1_data_ack", 8'h5A, 1'b0, 1'b0);
        bus_stop();
        check_reg("w1_reg3", 8'd3, 8'h5A);

        // Continuous write with pointer wrap.
        bus_start();
        write_byte("w2_addr_ack", 8'hA0, 1'b0, 1'b0);
        write_byte("w2_ptr_ack", 8'h0E, 1'b0, 1'b0);
        expect_wr(8'd14, 8'h11);
        write_byte("w2_d0_ack", 8'h11, 1'b0, 1'b0);
        expect_wr(8'd15, 8'h22);
        write_byte("w2_d1_ack", 8'h22, 1'b0, 1'b0);
        expect_wr(8'd0, 8'h33);
        write_byte("w2_d2_ack", 8'h33, 1'b0, 1'b0);
        bus_stop();
        check_reg("w2_reg14", 8'd14, 8'h11);
        check_reg("w2_reg15", 8'd15, 8'h22);
        check_reg("w2_reg0", 8'd0, 8'h33);

        // Current-address read from ptr 1: regs 1, 2, 3.
        bus_start();
        write_byte("r1_addr_ack", 8'hA1, 1'b0, 1'b0);
        read_byte("r1_byte1", 8'h00, 1'b0);
        read_byte("r1_byte2", 8'h00, 1'b0);
        read_byte("r1_byte3", 8'h5A, 1'b1);
        bus_stop();

        // Random read via repeated START.
        bus_start();
        write_byte("rr_addr_ack", 8'hA0, 1'b0, 1'b0);
        write_byte("rr_ptr_ack", 8'h0E, 1'b0, 1'b0);
        bus_start();
        write_byte("rr_raddr_ack", 8'hA1, 1'b0, 1'b0);
        read_byte("rr_byte14", 8'h11, 1'b0);
        read_byte("rr_byte15", 8'h22, 1'b1);
        check("rr_released", int'(sda_oen), 1);
        bus_stop();

        // Wrong address: never ACKs, never writes.
        check("na_busy_before", int'(busy), 0);
        oen_low_seen = 1'b0;
        bus_start();
        check("na_busy_during", int'(busy), 1);
        write_byte("na_addr_nack", 8'hA2, 1'b1, 1'b0);
        write_byte("na_b1_nack", 8'h03, 1'b1, 1'b0);
        write_byte("na_b2_nack", 8'hFF, 1'b1, 1'b0);
        bus_stop();
        check("na_busy_after", int'(busy), 0);
        check("na_oen_low", int'(oen_low_seen), 0);
        check_reg("na_reg3", 8'd3, 8'h5A);

        // 1-clk SCL glitch inside each byte.
        bus_start();
        write_byte("gl_addr_ack", 8'hA0, 1'b0, 1'b1);
        write_byte("gl_ptr_ack", 8'h07, 1'b0, 1'b1);
        expect_wr(8'd7, 8'hC3);
        write_byte("gl_data_ack", 8'hC3, 1'b0, 1'b1);
        bus_stop();
        check_reg("gl_reg7", 8'd7, 8'hC3);

        // Reset while driving a read bit 0 (ptr is 8, regs[8] = 0).
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(((8'hA1 >> i) & 8'h01) != 0, 1'b0);
        read_bit(a);
        check("rs_addr_ack", int'(a), 0);
        check("rs_driving", int'(sda_oen), 0);
        rst_n = 1'b0;
        #1;
        check("rs_released", int'(sda_oen), 1);
        check_reg("rs_reg3", 8'd3, 8'h00);
        check_reg("rs_reg7", 8'd7, 8'h00);
        wclk(3);
        rst_n = 1'b1;
        scl_m = 1'b1;
        wclk(H);
        check("rs_busy", int'(busy), 0);

        bus_start();
        write_byte("pr_addr_ack", 8'hA0, 1'b0, 1'b0);
        write_byte("pr_ptr_ack", 8'h00, 1'b0, 1'b0);
        expect_wr(8'd0, 8'h3C);
        write_byte("pr_data_ack", 8'h3C, 1'b0, 1'b0);
        bus_stop();
        check_reg("pr_reg0", 8'd0, 8'h3C);
        check_reg("pr_reg15", 8'd15, 8'h00);

        wclk(10);
        check("wr_queue_left", exp_wa.size(), 0);
        check("start_count", starts_seen, starts_exp);
        check("stop_count", stops_seen, stops_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
